// File: rtl/sdram_axi_serializer.sv
// Serializes an upstream AXI4 port onto the SDRAM AXI port so that at most one
// read or write is outstanding downstream; responses are forwarded unmodified.
module sdram_axi_serializer #(
  parameter logic [31:0] ADDR_MASK = 32'h01FF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  // upstream write address
  input  logic        in_awvalid,
  output logic        in_awready,
  input  logic [31:0] in_awaddr,
  input  logic [3:0]  in_awid,
  input  logic [7:0]  in_awlen,
  input  logic [2:0]  in_awsize,
  input  logic [1:0]  in_awburst,
  // upstream write data
  input  logic        in_wvalid,
  output logic        in_wready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_wlast,
  // upstream write response
  output logic        in_bvalid,
  input  logic        in_bready,
  output logic [1:0]  in_bresp,
  output logic [3:0]  in_bid,
  // upstream read address
  input  logic        in_arvalid,
  output logic        in_arready,
  input  logic [31:0] in_araddr,
  input  logic [3:0]  in_arid,
  input  logic [7:0]  in_arlen,
  input  logic [2:0]  in_arsize,
  input  logic [1:0]  in_arburst,
  // upstream read data
  output logic        in_rvalid,
  input  logic        in_rready,
  output logic [31:0] in_rdata,
  output logic [1:0]  in_rresp,
  output logic        in_rlast,
  output logic [3:0]  in_rid,
  // downstream write address
  output logic        out_awvalid,
  input  logic        out_awready,
  output logic [31:0] out_awaddr,
  output logic [3:0]  out_awid,
  output logic [7:0]  out_awlen,
  output logic [2:0]  out_awsize,
  output logic [1:0]  out_awburst,
  // downstream write data
  output logic        out_wvalid,
  input  logic        out_wready,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_wstrb,
  output logic        out_wlast,
  // downstream write response
  input  logic        out_bvalid,
  output logic        out_bready,
  input  logic [1:0]  out_bresp,
  input  logic [3:0]  out_bid,
  // downstream read address
  output logic        out_arvalid,
  input  logic        out_arready,
  output logic [31:0] out_araddr,
  output logic [3:0]  out_arid,
  output logic [7:0]  out_arlen,
  output logic [2:0]  out_arsize,
  output logic [1:0]  out_arburst,
  // downstream read data
  input  logic        out_rvalid,
  output logic        out_rready,
  input  logic [31:0] out_rdata,
  input  logic [1:0]  out_rresp,
  input  logic        out_rlast,
  input  logic [3:0]  out_rid
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AR_ISSUE = 2'd1,
    RD       = 2'd2,
    WR       = 2'd3
  } state_t;

  state_t      state_r;
  logic        rr_r;
  logic        aw_done_r;
  logic        w_done_r;
  logic        arvalid_r;
  logic        awvalid_r;
  logic [31:0] cap_addr_r;
  logic [3:0]  cap_id_r;
  logic [7:0]  cap_len_r;
  logic [2:0]  cap_size_r;
  logic [1:0]  cap_burst_r;

  logic        idle_s;
  logic        ar_grant_s;
  logic        aw_grant_s;
  logic        w_last_hs_s;
  logic        b_open_s;

  // Grants are masked while reset is held so nothing is accepted during reset.
  assign idle_s      = (state_r == IDLE) && !reset;
  assign ar_grant_s  = idle_s && in_arvalid && (!in_awvalid || !rr_r);
  assign aw_grant_s  = idle_s && in_awvalid && (!in_arvalid || rr_r);
  assign w_last_hs_s = (state_r == WR) && !w_done_r && in_wvalid && out_wready && in_wlast;
  assign b_open_s    = (state_r == WR) && aw_done_r && w_done_r;

  // Only one transaction is in flight, so read and write share one capture set.
  assign out_arvalid = arvalid_r;
  assign out_araddr  = cap_addr_r;
  assign out_arid    = cap_id_r;
  assign out_arlen   = cap_len_r;
  assign out_arsize  = cap_size_r;
  assign out_arburst = cap_burst_r;
  assign out_awvalid = awvalid_r;
  assign out_awaddr  = cap_addr_r;
  assign out_awid    = cap_id_r;
  assign out_awlen   = cap_len_r;
  assign out_awsize  = cap_size_r;
  assign out_awburst = cap_burst_r;

  assign out_wdata = in_wdata;
  assign out_wstrb = in_wstrb;
  assign out_wlast = in_wlast;
  assign in_bresp  = out_bresp;
  assign in_bid    = out_bid;
  assign in_rdata  = out_rdata;
  assign in_rresp  = out_rresp;
  assign in_rlast  = out_rlast;
  assign in_rid    = out_rid;

  // Transaction FSM: arbitration, field capture and downstream address valids.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_r        <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      awvalid_r   <= 1'b0;
      cap_addr_r  <= 32'd0;
      cap_id_r    <= 4'd0;
      cap_len_r   <= 8'd0;
      cap_size_r  <= 3'd0;
      cap_burst_r <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (ar_grant_s) begin
            cap_addr_r  <= in_araddr & ADDR_MASK;
            cap_id_r    <= in_arid;
            cap_len_r   <= in_arlen;
            cap_size_r  <= in_arsize;
            cap_burst_r <= in_arburst;
            rr_r        <= 1'b1;
            arvalid_r   <= 1'b1;
            state_r     <= AR_ISSUE;
          end else if (aw_grant_s) begin
            cap_addr_r  <= in_awaddr & ADDR_MASK;
            cap_id_r    <= in_awid;
            cap_len_r   <= in_awlen;
            cap_size_r  <= in_awsize;
            cap_burst_r <= in_awburst;
            rr_r        <= 1'b0;
            awvalid_r   <= 1'b1;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            state_r     <= WR;
          end else begin
            state_r <= IDLE;
          end
        end
        AR_ISSUE: begin
          if (out_arready) begin
            arvalid_r <= 1'b0;
            state_r   <= RD;
          end else begin
            state_r <= AR_ISSUE;
          end
        end
        RD: begin
          if (out_rvalid && in_rready && out_rlast) begin
            state_r <= IDLE;
          end else begin
            state_r <= RD;
          end
        end
        WR: begin
          if (awvalid_r && out_awready) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_last_hs_s) begin
            w_done_r <= 1'b1;
          end
          if (b_open_s && out_bvalid && in_bready) begin
            state_r <= IDLE;
          end else begin
            state_r <= WR;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Handshake routing: each channel is only connected inside its owning state.
  always_comb begin
    in_arready = 1'b0;
    in_awready = 1'b0;
    in_wready  = 1'b0;
    in_bvalid  = 1'b0;
    in_rvalid  = 1'b0;
    out_wvalid = 1'b0;
    out_bready = 1'b0;
    out_rready = 1'b0;
    case (state_r)
      IDLE: begin
        in_arready = ar_grant_s;
        in_awready = aw_grant_s;
      end
      RD: begin
        in_rvalid  = out_rvalid;
        out_rready = in_rready;
      end
      WR: begin
        if (!w_done_r) begin
          out_wvalid = in_wvalid;
          in_wready  = out_wready;
        end else begin
          out_wvalid = 1'b0;
          in_wready  = 1'b0;
        end
        if (b_open_s) begin
          in_bvalid  = out_bvalid;
          out_bready = in_bready;
        end else begin
          in_bvalid  = 1'b0;
          out_bready = 1'b0;
        end
      end
      default: begin
        in_arready = 1'b0;
        in_awready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_axi_serializer.sv
// Directed bench: stimulus pushes expected beats into per-channel queues and a
// negedge monitor pops and compares whenever a handshake is presented.
module tb_sdram_axi_serializer;

  logic        clock, reset;
  logic        in_awvalid, in_awready; logic [31:0] in_awaddr; logic [3:0] in_awid;
  logic [7:0]  in_awlen; logic [2:0] in_awsize; logic [1:0] in_awburst;
  logic        in_wvalid, in_wready; logic [31:0] in_wdata; logic [3:0] in_wstrb; logic in_wlast;
  logic        in_bvalid, in_bready; logic [1:0] in_bresp; logic [3:0] in_bid;
  logic        in_arvalid, in_arready; logic [31:0] in_araddr; logic [3:0] in_arid;
  logic [7:0]  in_arlen; logic [2:0] in_arsize; logic [1:0] in_arburst;
  logic        in_rvalid, in_rready; logic [31:0] in_rdata; logic [1:0] in_rresp;
  logic        in_rlast; logic [3:0] in_rid;
  logic        out_awvalid, out_awready; logic [31:0] out_awaddr; logic [3:0] out_awid;
  logic [7:0]  out_awlen; logic [2:0] out_awsize; logic [1:0] out_awburst;
  logic        out_wvalid, out_wready; logic [31:0] out_wdata; logic [3:0] out_wstrb; logic out_wlast;
  logic        out_bvalid, out_bready; logic [1:0] out_bresp; logic [3:0] out_bid;
  logic        out_arvalid, out_arready; logic [31:0] out_araddr; logic [3:0] out_arid;
  logic [7:0]  out_arlen; logic [2:0] out_arsize; logic [1:0] out_arburst;
  logic        out_rvalid, out_rready; logic [31:0] out_rdata; logic [1:0] out_rresp;
  logic        out_rlast; logic [3:0] out_rid;

  int n_cmp = 0;
  int n_fail = 0;
  logic [63:0] q_ar[$], q_aw[$], q_w[$], q_r[$], q_b[$];

  sdram_axi_serializer dut (
    .clock(clock), .reset(reset),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr), .in_awid(in_awid),
    .in_awlen(in_awlen), .in_awsize(in_awsize), .in_awburst(in_awburst),
    .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .in_wlast(in_wlast),
    .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bresp(in_bresp), .in_bid(in_bid),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr), .in_arid(in_arid),
    .in_arlen(in_arlen), .in_arsize(in_arsize), .in_arburst(in_arburst),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata), .in_rresp(in_rresp),
    .in_rlast(in_rlast), .in_rid(in_rid),
    .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr),
    .out_awid(out_awid), .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_wlast(out_wlast),
    .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp), .out_bid(out_bid),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr),
    .out_arid(out_arid), .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata), .out_rresp(out_rresp),
    .out_rlast(out_rlast), .out_rid(out_rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {63'd0, act}, {63'd0, exp});
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk(nm, {32'd0, act}, {32'd0, exp});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ar(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    in_arvalid = v; in_araddr = a; in_arid = id; in_arlen = len; in_arsize = 3'd2; in_arburst = 2'd1;
  endtask

  task automatic set_aw(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    in_awvalid = v; in_awaddr = a; in_awid = id; in_awlen = len; in_awsize = 3'd2; in_awburst = 2'd1;
  endtask

  task automatic set_w(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l);
    in_wvalid = v; in_wdata = d; in_wstrb = s; in_wlast = l;
  endtask

  task automatic set_r(input logic v, input logic [31:0] d, input logic [1:0] rs, input logic l,
                       input logic [3:0] id);
    out_rvalid = v; out_rdata = d; out_rresp = rs; out_rlast = l; out_rid = id;
  endtask

  // Expected downstream address beats always carry size 2, INCR burst.
  task automatic push_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    q_ar.push_back({15'd0, a, id, len, 3'd2, 2'd1});
  endtask

  task automatic push_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    q_aw.push_back({15'd0, a, id, len, 3'd2, 2'd1});
  endtask

  task automatic sb_pop(input int ch, input string nm, input logic [63:0] act);
    logic [63:0] e;
    logic ok;
    e = 64'd0;
    ok = 1'b1;
    case (ch)
      0: if (q_ar.size() > 0) e = q_ar.pop_front(); else ok = 1'b0;
      1: if (q_aw.size() > 0) e = q_aw.pop_front(); else ok = 1'b0;
      2: if (q_w.size() > 0)  e = q_w.pop_front();  else ok = 1'b0;
      3: if (q_r.size() > 0)  e = q_r.pop_front();  else ok = 1'b0;
      default: if (q_b.size() > 0) e = q_b.pop_front(); else ok = 1'b0;
    endcase
    if (ok) begin
      chk(nm, act, e);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: unexpected beat %h, expected none at %0t", nm, act, $time);
    end
  endtask

  // Monitor: every handshake on an observed channel is checked against its queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_arvalid && out_arready)
        sb_pop(0, "sb_ar", {15'd0, out_araddr, out_arid, out_arlen, out_arsize, out_arburst});
      if (out_awvalid && out_awready)
        sb_pop(1, "sb_aw", {15'd0, out_awaddr, out_awid, out_awlen, out_awsize, out_awburst});
      if (out_wvalid && out_wready)
        sb_pop(2, "sb_w", {27'd0, out_wdata, out_wstrb, out_wlast});
      if (in_rvalid && in_rready)
        sb_pop(3, "sb_r", {25'd0, in_rdata, in_rresp, in_rlast, in_rid});
      if (in_bvalid && in_bready)
        sb_pop(4, "sb_b", {58'd0, in_bresp, in_bid});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_ar(1'b0, 32'd0, 4'd0, 8'd0); set_aw(1'b0, 32'd0, 4'd0, 8'd0); set_w(1'b0, 32'd0, 4'd0, 1'b0);
    set_r(1'b0, 32'd0, 2'd0, 1'b0, 4'd0);
    in_bready = 1'b0; in_rready = 1'b0; out_awready = 1'b0; out_wready = 1'b0;
    out_arready = 1'b0; out_bvalid = 1'b0; out_bresp = 2'd0; out_bid = 4'd0;
    tick(); tick();

    // Reset state, with both requests already waiting.
    set_ar(1'b1, 32'hA000_1234, 4'd5, 8'd3);
    set_aw(1'b1, 32'hFF00_0040, 4'd3, 8'd1);
    #1;
    chk1("rst_arvalid", out_arvalid, 1'b0);
    chk1("rst_awvalid", out_awvalid, 1'b0);
    chk1("rst_arready", in_arready, 1'b0);
    chk1("rst_awready", in_awready, 1'b0);
    chk1("rst_wready", in_wready, 1'b0);
    chk1("rst_bvalid", in_bvalid, 1'b0);
    chk1("rst_rvalid", in_rvalid, 1'b0);
    tick();
    reset = 1'b0;
    push_ar(32'h0000_1234, 4'd5, 8'd3);
    #1;
    chk1("conflict_read_first", in_arready, 1'b1);
    chk1("conflict_write_waits", in_awready, 1'b0);
    chk1("arvalid_before_hs", out_arvalid, 1'b0);
    tick();
    set_ar(1'b0, 32'd0, 4'd0, 8'd0);
    #1;
    chk1("arvalid_latency", out_arvalid, 1'b1);
    chk32("araddr_masked", out_araddr, 32'h0000_1234);
    chk1("awready_in_ar_issue", in_awready, 1'b0);
    out_arready = 1'b1;
    tick();
    out_arready = 1'b0;
    #1;
    chk1("arvalid_drops", out_arvalid, 1'b0);

    // Four read beats; SLVERR on beat 3 and one stall cycle on beat 2.
    in_rready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      set_r(1'b1, 32'hD000_0000 + 32'(b), (b == 2) ? 2'b10 : 2'b00, (b == 3), 4'd5);
      q_r.push_back({25'd0, 32'hD000_0000 + 32'(b), (b == 2) ? 2'b10 : 2'b00, (b == 3), 4'd5});
      if (b == 1) begin
        in_rready = 1'b0;
        #1;
        chk1("rready_backpressure", out_rready, 1'b0);
        chk1("rvalid_passthrough", in_rvalid, 1'b1);
        tick();
        in_rready = 1'b1;
      end
      tick();
    end
    set_r(1'b0, 32'd0, 2'd0, 1'b0, 4'd0);
    #1;
    chk1("write_granted_first_idle", in_awready, 1'b1);
    chk1("rvalid_after_rlast", in_rvalid, 1'b0);
    push_aw(32'h0100_0040, 4'd3, 8'd1);
    tick();
    set_aw(1'b0, 32'd0, 4'd0, 8'd0);
    #1;
    chk1("awvalid_latency", out_awvalid, 1'b1);
    chk32("awaddr_masked", out_awaddr, 32'h0100_0040);

    // W ahead of AW: two beats, then an extra beat that must be blocked.
    out_wready = 1'b1;
    set_w(1'b1, 32'h1111_1111, 4'hF, 1'b0);
    q_w.push_back({27'd0, 32'h1111_1111, 4'hF, 1'b0});
    tick();
    set_w(1'b1, 32'h2222_2222, 4'h3, 1'b1);
    q_w.push_back({27'd0, 32'h2222_2222, 4'h3, 1'b1});
    tick();
    set_w(1'b1, 32'h3333_3333, 4'hF, 1'b1);
    out_bvalid = 1'b1; out_bresp = 2'b00; out_bid = 4'd3; in_bready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk1("extra_w_wready", in_wready, 1'b0);
      chk1("extra_w_wvalid", out_wvalid, 1'b0);
      chk1("b_held_before_aw", in_bvalid, 1'b0);
      chk1("bready_held_before_aw", out_bready, 1'b0);
      tick();
    end
    q_b.push_back({58'd0, 2'b00, 4'd3});
    out_awready = 1'b1;
    tick();
    out_awready = 1'b0;
    #1;
    chk1("awvalid_after_hs", out_awvalid, 1'b0);
    chk1("b_open_after_aw", in_bvalid, 1'b1);
    tick();
    out_bvalid = 1'b0; in_bready = 1'b0;
    set_w(1'b0, 32'd0, 4'd0, 1'b0);

    // AR backpressure: fields stable and a second AR held off.
    set_ar(1'b1, 32'h1234_5678, 4'd9, 8'd0);
    push_ar(32'h0034_5678, 4'd9, 8'd0);
    #1;
    chk1("lone_read_grant", in_arready, 1'b1);
    tick();
    set_ar(1'b1, 32'h8765_4320, 4'hA, 8'd3);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk1("bp_arvalid_stable", out_arvalid, 1'b1);
      chk32("bp_araddr_stable", out_araddr, 32'h0034_5678);
      chk1("bp_second_ar_blocked", in_arready, 1'b0);
      tick();
    end
    out_arready = 1'b1;
    tick();
    out_arready = 1'b0;
    set_aw(1'b1, 32'h0000_0100, 4'd2, 8'd0);
    set_r(1'b1, 32'hCAFE_F00D, 2'b11, 1'b1, 4'd9);
    in_rready = 1'b1;
    q_r.push_back({25'd0, 32'hCAFE_F00D, 2'b11, 1'b1, 4'd9});
    tick();
    set_r(1'b0, 32'd0, 2'd0, 1'b0, 4'd0);
    #1;
    chk1("rr_write_wins", in_awready, 1'b1);
    chk1("rr_read_loses", in_arready, 1'b0);
    push_aw(32'h0000_0100, 4'd2, 8'd0);
    tick();
    set_aw(1'b0, 32'd0, 4'd0, 8'd0);
    out_awready = 1'b1;
    tick();
    out_awready = 1'b0;
    set_w(1'b1, 32'h5555_AAAA, 4'hA, 1'b1);
    q_w.push_back({27'd0, 32'h5555_AAAA, 4'hA, 1'b1});
    #1;
    chk1("b_closed_before_w", in_bvalid, 1'b0);
    chk1("w_passthrough_ready", in_wready, 1'b1);
    tick();
    set_w(1'b0, 32'd0, 4'd0, 1'b0);
    out_bvalid = 1'b1; out_bresp = 2'b10; out_bid = 4'd2; in_bready = 1'b1;
    q_b.push_back({58'd0, 2'b10, 4'd2});
    tick();
    out_bvalid = 1'b0; in_bready = 1'b0;
    set_aw(1'b1, 32'h0000_0200, 4'd6, 8'd0);
    #1;
    chk1("rr_read_wins_again", in_arready, 1'b1);
    chk1("rr_write_loses", in_awready, 1'b0);
    push_ar(32'h0165_4320, 4'hA, 8'd3);
    tick();
    set_ar(1'b0, 32'd0, 4'd0, 8'd0);
    set_aw(1'b0, 32'd0, 4'd0, 8'd0);
    out_arready = 1'b1;
    tick();
    out_arready = 1'b0;

    // Reset during beat 2 of 4.
    set_r(1'b1, 32'h4444_0000, 2'b00, 1'b0, 4'hA);
    q_r.push_back({25'd0, 32'h4444_0000, 2'b00, 1'b0, 4'hA});
    tick();
    set_r(1'b1, 32'h4444_0001, 2'b00, 1'b0, 4'hA);
    #2;
    reset = 1'b1;
    #1;
    chk1("async_rst_rvalid", in_rvalid, 1'b0);
    chk1("async_rst_rready", out_rready, 1'b0);
    chk1("async_rst_arvalid", out_arvalid, 1'b0);
    tick();
    reset = 1'b0;
    set_r(1'b1, 32'h9999_9999, 2'b00, 1'b1, 4'hA);
    #1;
    chk1("no_stray_beat", in_rvalid, 1'b0);
    chk1("no_stray_rready", out_rready, 1'b0);
    tick();
    set_r(1'b0, 32'd0, 2'd0, 1'b0, 4'd0);
    set_ar(1'b1, 32'h0000_0ABC, 4'd1, 8'd1);
    push_ar(32'h0000_0ABC, 4'd1, 8'd1);
    #1;
    chk1("post_rst_grant", in_arready, 1'b1);
    tick();
    set_ar(1'b0, 32'd0, 4'd0, 8'd0);
    out_arready = 1'b1;
    tick();
    out_arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      set_r(1'b1, 32'h7700_0000 + 32'(b), 2'b00, (b == 1), 4'd1);
      q_r.push_back({25'd0, 32'h7700_0000 + 32'(b), 2'b00, (b == 1), 4'd1});
      tick();
    end
    set_r(1'b0, 32'd0, 2'd0, 1'b0, 4'd0);
    in_rready = 1'b0;
    #1;
    chk1("post_rst_idle", in_rvalid, 1'b0);
    chk("sb_all_consumed", 64'(q_ar.size() + q_aw.size() + q_w.size() + q_r.size() + q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_axi_serializer.md
SDRAM_AXI_SERIALIZER -- requirements
Module: sdram_axi_serializer

Interface
REQ-001 Parameter ADDR_MASK, default 32'h01FF_FFFF: AND mask applied to forwarded araddr/awaddr (32 MB SDRAM window).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 in_aw{valid,ready,addr,id,len,size,burst}  in/out/in...  1/1/32/4/8/3/2  upstream AXI4 write address channel (ready is the output).
REQ-005 in_w{valid,ready,data,strb,last}  in/out/in/in/in  1/1/32/4/1  upstream write data channel.
REQ-006 in_b{valid,ready,resp,id}  out/in/out/out  1/1/2/4  upstream write response channel.
REQ-007 in_ar{valid,ready,addr,id,len,size,burst}  in/out/in...  1/1/32/4/8/3/2  upstream read address channel (ready is the output).
REQ-008 in_r{valid,ready,data,resp,last,id}  out/in/out/out/out/out  1/1/32/2/1/4  upstream read data channel.
REQ-009 out_aw*, out_w*, out_b*, out_ar*, out_r*  mirror directions/widths of REQ-004..008  downstream AXI4 port, connected to the SDRAM AXI top (in_* side).

Function
REQ-010 Block SHALL allow at most one outstanding transaction (read or write) toward the downstream port at any time.
REQ-011 FSM states: IDLE, AR_ISSUE, RD, WR; reset state IDLE.
REQ-012 In IDLE, in_arready = ar_grant, in_awready = aw_grant; all other upstream readies and valids SHALL be 0.
REQ-013 Arbitration: only one valid -> grant it; both valid -> grant per 1-bit round-robin pointer rr (0=read first); rr toggles to the loser after every grant; rr resets to 0.
REQ-014 On AR handshake in IDLE: capture addr&ADDR_MASK, id, len, size, burst into registers; next state AR_ISSUE.
REQ-015 AR_ISSUE: out_arvalid=1 with registered fields; on out_arready -> RD; out_arvalid SHALL drop the cycle after handshake.
REQ-016 RD: R channel passes combinationally (out_rvalid->in_rvalid, in_rready->out_rready, data/resp/last/id unchanged); on R handshake with rlast=1 -> IDLE.
REQ-017 On AW handshake in IDLE: capture addr&ADDR_MASK, id, len, size, burst; clear flags aw_done, w_done; next state WR.
REQ-018 WR: out_awvalid = !aw_done; out_awready handshake sets aw_done.
REQ-019 WR: W passes combinationally while !w_done (valid, ready, data, strb, last); W handshake with wlast=1 sets w_done; while w_done, in_wready=0, out_wvalid=0.
REQ-020 WR: W beats SHALL be forwarded before aw_done is set (AXI permits W ahead of AW).
REQ-021 WR: B passes combinationally only when aw_done && w_done; otherwise in_bvalid=0, out_bready=0; B handshake -> IDLE.
REQ-022 Address latency: first downstream arvalid/awvalid SHALL appear exactly 1 cycle after the upstream handshake.
REQ-023 Outside the owning state, every upstream valid/ready and every downstream valid/ready SHALL be 0; data fields are don't-care.
REQ-024 Return to IDLE and re-grant in the next cycle: a new request waiting at IDLE SHALL be accepted in the first IDLE cycle (no bubble beyond that).
REQ-025 Responses (bresp/rresp, ids) SHALL be forwarded unmodified, including SLVERR/DECERR.

Reset
REQ-026 On reset: state IDLE, rr=0, aw_done=w_done=0, captured registers 0; out_arvalid, out_awvalid, out_wvalid, out_bready, out_rready, in_bvalid, in_rvalid, in_wready = 0.
REQ-027 Reset mid-transaction SHALL abandon it silently; no partial beats or responses are emitted after deassertion.

Verification
REQ-028 Single read: araddr=32'hA000_1234, arlen=3, arid=5 -> out_araddr=32'h0000_1234 one cycle later; 4 R beats forwarded; in_rlast on beat 4; state IDLE after.
REQ-029 Simultaneous arvalid and awvalid from reset -> read granted first; write granted in first IDLE cycle after rlast; rr=1 then 0 on next conflicting pair.
REQ-030 Write with W first: wvalid with 2 beats (awlen=1) before out_awready -> both beats forwarded, in_bvalid held 0 until AW handshake, then bresp=0 forwarded.
REQ-031 Backpressure: out_arready low 5 cycles -> out_arvalid and fields stable; in_arready stays 0 for a second AR.
REQ-032 Reset asserted during RD beat 2 of 4 -> all valids 0 asynchronously; after release, new read completes normally.
REQ-033 Extra in_wvalid after wlast -> in_wready=0, out_wvalid=0 until next WR transaction.
